spike_scheduler: RTL and testbench



---
 rtl/snn_sched_pkg.sv | 26 ++
 rtl/spike_sched_row.sv | 30 +++
 rtl/spike_scheduler.sv | 92 +++++++++
 tb/tb_spike_scheduler.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/snn_sched_pkg.sv
// snn_sched_pkg: shared defaults and helpers for the spike scheduler.
//   Geometry defaults : TICK_BITS, AXON_BITS, NUM_TICKS, NUM_AXONS, PACKET_WIDTH
//   Field slices      : DT_MSB/DT_LSB (delivery-tick offset), AXON_MSB/AXON_LSB
//   target_row()      : bitmap row that a packet lands in, relative to cur_slot
package snn_sched_pkg;

  localparam int unsigned TICK_BITS    = 4;
  localparam int unsigned AXON_BITS    = 8;
  localparam int unsigned NUM_TICKS    = 16;
  localparam int unsigned NUM_AXONS    = 256;
  localparam int unsigned PACKET_WIDTH = TICK_BITS + AXON_BITS;

  localparam int unsigned DT_MSB   = PACKET_WIDTH - 1;
  localparam int unsigned DT_LSB   = PACKET_WIDTH - TICK_BITS;
  localparam int unsigned AXON_MSB = AXON_BITS - 1;
  localparam int unsigned AXON_LSB = 0;

  // Natural TICK_BITS wrap gives the circular row index.
  function automatic logic [TICK_BITS-1:0] target_row(
    input logic [TICK_BITS-1:0] cur,
    input logic [TICK_BITS-1:0] dt
  );
    return cur + dt;
  endfunction

endpackage

// File: rtl/spike_sched_row.sv
// spike_sched_row: one NUM_AXONS-bit row of the spike bitmap.
//   clk      in   system clock
//   reset    in   synchronous active-high clear of the row
//   set_en   in   set bit set_idx at the next edge (OR, idempotent)
//   set_idx  in   axon index to set
//   clear    in   clear the whole row at the next edge (wins over set_en)
//   bits     out  current row contents
module spike_sched_row #(
  parameter int unsigned NUM_AXONS = 256,
  parameter int unsigned AXON_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 set_en,
  input  logic [AXON_BITS-1:0] set_idx,
  input  logic                 clear,
  output logic [NUM_AXONS-1:0] bits
);

  // A set coinciding with clear is delivered by the top-level forward path,
  // so dropping it here is what keeps delivery to exactly once.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      bits <= '0;
    end else if (set_en) begin
      bits[set_idx] <= 1'b1;
    end
  end

endmodule

// File: rtl/spike_scheduler.sv
// spike_scheduler: circular NUM_TICKS x NUM_AXONS spike bitmap fed by the
// router's local output; on each global tick the due row is presented as a
// registered axon vector and cleared for reuse.
//   clk              in   system clock
//   reset_n          in   synchronous reset, active-high (legacy name)
//   din              in   packet {dt, axon}
//   din_wen          in   din valid this cycle, no backpressure
//   tick             in   single-cycle global tick pulse
//   axon_spikes      out  row due at the most recent tick (held between ticks)
//   spikes_valid     out  one-cycle pulse after each tick
//   cur_slot         out  current read pointer
//   collision_count  out  saturating duplicate-spike counter, present only
//                         when SPIKE_SCHEDULER_COLLISION_CNT_EN is defined
module spike_scheduler #(
  parameter int unsigned PACKET_WIDTH = snn_sched_pkg::PACKET_WIDTH,
  parameter int unsigned TICK_BITS    = snn_sched_pkg::TICK_BITS,
  parameter int unsigned AXON_BITS    = snn_sched_pkg::AXON_BITS,
  parameter int unsigned NUM_TICKS    = snn_sched_pkg::NUM_TICKS,
  parameter int unsigned NUM_AXONS    = snn_sched_pkg::NUM_AXONS
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [PACKET_WIDTH-1:0] din,
  input  logic                    din_wen,
  input  logic                    tick,
  output logic [NUM_AXONS-1:0]    axon_spikes,
  output logic                    spikes_valid,
  output logic [TICK_BITS-1:0]    cur_slot
`ifdef SPIKE_SCHEDULER_COLLISION_CNT_EN
  ,
  output logic [15:0]             collision_count
`endif
);

  import snn_sched_pkg::*;

  logic [TICK_BITS-1:0] dt;
  logic [AXON_BITS-1:0] axon;
  logic [TICK_BITS-1:0] wr_row;
  logic                 fwd;
  logic [NUM_AXONS-1:0] fwd_mask;
  logic [NUM_AXONS-1:0] row_bits [NUM_TICKS];

  assign dt     = din[PACKET_WIDTH-1 -: TICK_BITS];
  assign axon   = din[AXON_BITS-1:0];
  assign wr_row = target_row(cur_slot, dt);

  // Write into the row being read and cleared this cycle: bypass it straight
  // into the output so the spike is not lost to the clear.
  assign fwd      = din_wen && tick && (wr_row == cur_slot);
  assign fwd_mask = fwd ? (NUM_AXONS'(1) << axon) : '0;

  for (genvar i = 0; i < NUM_TICKS; i++) begin : g_row
    spike_sched_row #(
      .NUM_AXONS(NUM_AXONS),
      .AXON_BITS(AXON_BITS)
    ) u_row (
      .clk    (clk),
      .reset  (reset_n),
      .set_en (din_wen && (wr_row == TICK_BITS'(i))),
      .set_idx(axon),
      .clear  (tick && (cur_slot == TICK_BITS'(i))),
      .bits   (row_bits[i])
    );
  end

  always_ff @(posedge clk) begin
    if (reset_n) begin
      cur_slot     <= '0;
      axon_spikes  <= '0;
      spikes_valid <= 1'b0;
    end else begin
      spikes_valid <= tick;
      if (tick) begin
        axon_spikes <= row_bits[cur_slot] | fwd_mask;
        cur_slot    <= cur_slot + TICK_BITS'(1);
      end
    end
  end

`ifdef SPIKE_SCHEDULER_COLLISION_CNT_EN
  // The forwarded case reads the same stored row, so one lookup covers both.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      collision_count <= '0;
    end else if (din_wen && row_bits[wr_row][axon] && (collision_count != '1)) begin
      collision_count <= collision_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_spike_scheduler.sv
module tb_spike_scheduler;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [11:0]  din;
  logic         din_wen;
  logic         tick;
  logic [255:0] axon_spikes;
  logic         spikes_valid;
  logic [3:0]   cur_slot;
`ifdef SPIKE_SCHEDULER_COLLISION_CNT_EN
  logic [15:0]  collision_count;
`endif

  always #5 clk = ~clk;

  spike_scheduler dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .din            (din),
    .din_wen        (din_wen),
    .tick           (tick),
    .axon_spikes    (axon_spikes),
    .spikes_valid   (spikes_valid),
    .cur_slot       (cur_slot)
`ifdef SPIKE_SCHEDULER_COLLISION_CNT_EN
    ,
    .collision_count(collision_count)
`endif
  );

  int unsigned total = 0;
  int unsigned bad   = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: each accepted spike is a pending entry tagged with the absolute
  // tick number at which it is due; the pointer is just ticks-since-reset.
  typedef struct {
    int unsigned due;
    int unsigned axon;
  } pend_t;

  pend_t        pend[$];
  int unsigned  tick_n  = 0;
  logic [255:0] m_spikes = '0;
  logic         m_valid  = 1'b0;
  int unsigned  m_coll   = 0;
  bit           m_ready  = 1'b0;
  int unsigned  m_due;
  bit           m_dup;

  always @(posedge clk) begin
    if (reset_n) begin
      pend.delete();
      tick_n   = 0;
      m_spikes = '0;
      m_valid  = 1'b0;
      m_coll   = 0;
      m_ready  = 1'b1;
    end else begin
      m_valid = tick;
      if (din_wen) begin
        m_due = tick_n + int'(din[11:8]) + 1;
        m_dup = 1'b0;
        foreach (pend[k])
          if (pend[k].due == m_due && pend[k].axon == int'(din[7:0])) m_dup = 1'b1;
        if (m_dup) begin
          if (m_coll < 65535) m_coll++;
        end else begin
          pend.push_back('{m_due, int'(din[7:0])});
        end
      end
      if (tick) begin
        tick_n++;
        m_spikes = '0;
        for (int k = int'(pend.size()) - 1; k >= 0; k--) begin
          if (pend[k].due == tick_n) begin
            m_spikes[pend[k].axon] = 1'b1;
            pend.delete(k);
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_ready) begin
      chk("valid_vs_model", 256'(spikes_valid), 256'(m_valid));
      chk("slot_vs_model", 256'(cur_slot), 256'(tick_n % 16));
      chk("spikes_vs_model", axon_spikes, m_spikes);
`ifdef SPIKE_SCHEDULER_COLLISION_CNT_EN
      chk("coll_vs_model", 256'(collision_count), 256'(m_coll));
`endif
    end
  end

  task automatic step(input logic r, input logic w, input logic [3:0] dt,
                      input logic [7:0] ax, input logic t);
    reset_n = r;
    din_wen = w;
    din     = {dt, ax};
    tick    = t;
    @(negedge clk);
    reset_n = 1'b0;
    din_wen = 1'b0;
    din     = '0;
    tick    = 1'b0;
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 4'd0, 8'd0, 1'b0);
  endtask

  task automatic do_tick();
    step(1'b0, 1'b0, 4'd0, 8'd0, 1'b1);
  endtask

  task automatic do_write(input logic [3:0] dt, input logic [7:0] ax);
    step(1'b0, 1'b1, dt, ax, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    do_reset();
    do_reset();
    chk("reset_slot", 256'(cur_slot), 256'd0);
    chk("reset_spikes", axon_spikes, '0);
    chk("reset_valid", 256'(spikes_valid), 256'd0);

    // Three empty ticks, back to back
    for (int i = 0; i < 3; i++) begin
      do_tick();
      chk("empty_tick_valid", 256'(spikes_valid), 256'd1);
      chk("empty_tick_spikes", axon_spikes, '0);
    end
    step(1'b0, 1'b0, 4'd0, 8'd0, 1'b0);
    chk("empty_idle_valid", 256'(spikes_valid), 256'd0);
    chk("empty_slot3", 256'(cur_slot), 256'd3);

    // dt=2, axon=5 at slot 0 -> after the 3rd tick only
    do_reset();
    do_write(4'd2, 8'd5);
    do_tick(); chk("dt2_t1_bit5", 256'(axon_spikes[5]), 256'd0);
    do_tick(); chk("dt2_t2_bit5", 256'(axon_spikes[5]), 256'd0);
    do_tick(); chk("dt2_t3_bit5", 256'(axon_spikes[5]), 256'd1);
    chk("dt2_t3_row", axon_spikes, 256'd1 << 5);
    do_idle_hold();
    do_tick(); chk("dt2_t4_bit5", 256'(axon_spikes[5]), 256'd0);

    // Wrap: slot 14 + dt 3 -> row 1, due at 4th tick
    do_reset();
    for (int i = 0; i < 14; i++) do_tick();
    chk("wrap_slot14", 256'(cur_slot), 256'd14);
    do_write(4'd3, 8'd255);
    for (int i = 1; i <= 3; i++) begin
      do_tick();
      chk("wrap_early_bit255", 256'(axon_spikes[255]), 256'd0);
    end
    do_tick();
    chk("wrap_t4_bit255", 256'(axon_spikes[255]), 256'd1);
    chk("wrap_slot2", 256'(cur_slot), 256'd2);

    // Same-cycle write dt=0 with tick -> forwarded, delivered exactly once
    step(1'b0, 1'b1, 4'd0, 8'd7, 1'b1);
    chk("fwd_bit7", 256'(axon_spikes[7]), 256'd1);
    chk("fwd_valid", 256'(spikes_valid), 256'd1);
    for (int i = 0; i < 16; i++) begin
      do_tick();
      chk("fwd_again_bit7", 256'(axon_spikes[7]), 256'd0);
    end

    // Forwarded write hitting an already-set bit
    do_reset();
    do_write(4'd0, 8'd3);
    step(1'b0, 1'b1, 4'd0, 8'd3, 1'b1);
    chk("fwddup_row", axon_spikes, 256'd1 << 3);
`ifdef SPIKE_SCHEDULER_COLLISION_CNT_EN
    chk("fwddup_coll", 256'(collision_count), 256'd1);
`endif
    do_tick();
    chk("fwddup_once", 256'(axon_spikes[3]), 256'd0);

    // Duplicate packets dt=1 axon=9 back to back
    do_reset();
    do_write(4'd1, 8'd9);
    do_write(4'd1, 8'd9);
    do_tick(); chk("dup_t1_bit9", 256'(axon_spikes[9]), 256'd0);
    do_tick(); chk("dup_t2_bit9", 256'(axon_spikes[9]), 256'd1);
    do_tick(); chk("dup_t3_bit9", 256'(axon_spikes[9]), 256'd0);
`ifdef SPIKE_SCHEDULER_COLLISION_CNT_EN
    chk("dup_coll", 256'(collision_count), 256'd1);
`endif

    // Reset with pending spikes and a simultaneous tick
    do_write(4'd0, 8'd1);
    do_write(4'd3, 8'd2);
    do_write(4'd5, 8'd3);
    step(1'b1, 1'b1, 4'd0, 8'd4, 1'b1);
    chk("rst_spikes", axon_spikes, '0);
    chk("rst_valid", 256'(spikes_valid), 256'd0);
    chk("rst_slot", 256'(cur_slot), 256'd0);
`ifdef SPIKE_SCHEDULER_COLLISION_CNT_EN
    chk("rst_coll", 256'(collision_count), 256'd0);
`endif
    for (int i = 0; i < 16; i++) begin
      do_tick();
      chk("rst_after_spikes", axon_spikes, '0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  task automatic do_idle_hold();
    step(1'b0, 1'b0, 4'd0, 8'd0, 1'b0);
    chk("hold_bit5", 256'(axon_spikes[5]), 256'd1);
    chk("hold_valid", 256'(spikes_valid), 256'd0);
  endtask

endmodule
